// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums NUM_INPUTS signed products per neuron and forwards non-data beats.
// Define ACC_SAT_EN for saturating adds; otherwise the sum wraps modulo 2^SSUM_WIDTH.
module neuron_accumulator #(
  parameter int TYPE_WIDTH = 2,
  parameter int SEQ_WIDTH  = 8,
  parameter int PROD_WIDTH = 16,
  parameter int SSUM_WIDTH = 24,
  parameter int NUM_INPUTS = 4,
  parameter int DATA_TYPE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hlt,
  input  logic                  MUL_ACC_valid,
  input  logic [TYPE_WIDTH-1:0] MUL_ACC_type,
  input  logic [SEQ_WIDTH-1:0]  MUL_ACC_seqNum,
  input  logic [PROD_WIDTH-1:0] MUL_ACC_data,
  output logic                  ACC_AF_valid,
  output logic [TYPE_WIDTH-1:0] ACC_AF_type,
  output logic [SEQ_WIDTH-1:0]  ACC_AF_seqNum,
  output logic [SSUM_WIDTH-1:0] ACC_AF_data,
  output logic                  ACC_err
);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_n;
  logic signed [SSUM_WIDTH-1:0] sum, sum_d, sum_n, ext, base;
  logic signed [SSUM_WIDTH:0] raw;
  logic [SEQ_WIDTH-1:0] seq, seq_d;
  logic is_data, same, done;
  logic v_d, e_d;
  logic [TYPE_WIDTH-1:0] t_d;
  logic [SEQ_WIDTH-1:0] s_d;
  logic [SSUM_WIDTH-1:0] d_d;
  always_comb begin
    ext = SSUM_WIDTH'($signed(MUL_ACC_data));
    is_data = MUL_ACC_type == TYPE_WIDTH'(DATA_TYPE);
    same = state == ACCUM && MUL_ACC_seqNum == seq;
    base = same ? sum : '0;
    raw = (SSUM_WIDTH+1)'(base) + (SSUM_WIDTH+1)'(ext);
`ifdef ACC_SAT_EN
    sum_n = raw[SSUM_WIDTH] != raw[SSUM_WIDTH-1] ?
            (raw[SSUM_WIDTH] ? {1'b1, {(SSUM_WIDTH-1){1'b0}}} : {1'b0, {(SSUM_WIDTH-1){1'b1}}}) :
            raw[SSUM_WIDTH-1:0];
`else
    sum_n = raw[SSUM_WIDTH-1:0];
`endif
    cnt_n = same ? cnt + CW'(1) : CW'(1);
    done = cnt_n == CW'(NUM_INPUTS);
    state_d = state;
    cnt_d = cnt;
    sum_d = sum;
    seq_d = seq;
    v_d = 1'b0;
    e_d = 1'b0;
    t_d = ACC_AF_type;
    s_d = ACC_AF_seqNum;
    d_d = ACC_AF_data;
    if (MUL_ACC_valid && is_data) begin
      // a seqNum change mid-neuron restarts the sum with this beat
      e_d = state == ACCUM && !same;
      seq_d = MUL_ACC_seqNum;
      sum_d = done ? '0 : sum_n;
      cnt_d = done ? '0 : cnt_n;
      state_d = done ? IDLE : ACCUM;
      v_d = done;
      t_d = done ? TYPE_WIDTH'(DATA_TYPE) : ACC_AF_type;
      s_d = done ? MUL_ACC_seqNum : ACC_AF_seqNum;
      d_d = done ? sum_n : ACC_AF_data;
    end else if (MUL_ACC_valid) begin
      v_d = 1'b1;
      t_d = MUL_ACC_type;
      s_d = MUL_ACC_seqNum;
      d_d = ext;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sum <= '0;
      seq <= '0;
      ACC_AF_valid <= 1'b0;
      ACC_AF_type <= '0;
      ACC_AF_seqNum <= '0;
      ACC_AF_data <= '0;
      ACC_err <= 1'b0;
    end else if (!hlt) begin
      state <= state_d;
      cnt <= cnt_d;
      sum <= sum_d;
      seq <= seq_d;
      ACC_AF_valid <= v_d;
      ACC_AF_type <= t_d;
      ACC_AF_seqNum <= s_d;
      ACC_AF_data <= d_d;
      ACC_err <= e_d;
    end
  end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed and random beats against a beat-level model, 24- and 16-bit sums.
module tb_neuron_accumulator;
  logic clk = 1'b0;
  logic rst, hlt, v;
  logic [1:0] t;
  logic [7:0] s;
  logic [15:0] d;
  logic a_v, a_e, b_v, b_e;
  logic [1:0] a_t, b_t;
  logic [7:0] a_s, b_s;
  logic [23:0] a_d;
  logic [15:0] b_d;
  int vec = 0, bad = 0;
  bit act;
  int n;
  logic [7:0] mseq;
  longint acc24, acc16, mx;
  logic ev, ee;
  logic [1:0] et;
  logic [7:0] es;
  logic [23:0] ed24;
  logic [15:0] ed16;

  neuron_accumulator u24 (
    .clk(clk), .rst(rst), .hlt(hlt),
    .MUL_ACC_valid(v), .MUL_ACC_type(t), .MUL_ACC_seqNum(s), .MUL_ACC_data(d),
    .ACC_AF_valid(a_v), .ACC_AF_type(a_t), .ACC_AF_seqNum(a_s), .ACC_AF_data(a_d),
    .ACC_err(a_e));

  neuron_accumulator #(.SSUM_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .hlt(hlt),
    .MUL_ACC_valid(v), .MUL_ACC_type(t), .MUL_ACC_seqNum(s), .MUL_ACC_data(d),
    .ACC_AF_valid(b_v), .ACC_AF_type(b_t), .ACC_AF_seqNum(b_s), .ACC_AF_data(b_d),
    .ACC_err(b_e));

  always #5 clk = ~clk;

  function automatic longint addw(input longint a, input longint b, input int w);
    longint r, hi, lo;
    r = a + b;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
`ifdef ACC_SAT_EN
    r = r > hi ? hi : (r < lo ? lo : r);
`else
    r = r & ((longint'(1) << w) - 1);
    if (r > hi) r = r - (longint'(1) << w);
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ev = 0; ee = 0; et = 0; es = 0; ed24 = 0; ed16 = 0; act = 0; n = 0;
    end else if (!hlt) begin
      ev = 0;
      ee = 0;
      if (v && t == 2'd0) begin
        mx = longint'($signed(d));
        if (act && s == mseq) begin
          acc24 = addw(acc24, mx, 24);
          acc16 = addw(acc16, mx, 16);
          n++;
        end else begin
          ee = act;
          act = 1;
          mseq = s;
          acc24 = mx;
          acc16 = mx;
          n = 1;
        end
        if (n == 4) begin
          ev = 1; et = 0; es = mseq; ed24 = acc24[23:0]; ed16 = acc16[15:0]; act = 0;
        end
      end else if (v) begin
        ev = 1; et = t; es = s; ed24 = 24'($signed(d)); ed16 = d;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    vec++;
    cmp(nm, a, e);
  endtask

  always @(negedge clk) begin
    vec++;
    cmp("valid24", 32'(a_v), 32'(ev));
    cmp("type24", 32'(a_t), 32'(et));
    cmp("seq24", 32'(a_s), 32'(es));
    cmp("data24", 32'(a_d), 32'(ed24));
    cmp("err24", 32'(a_e), 32'(ee));
    cmp("valid16", 32'(b_v), 32'(ev));
    cmp("data16", 32'(b_d), 32'(ed16));
    cmp("err16", 32'(b_e), 32'(ee));
  end

  task automatic beat(input logic [1:0] tt, input logic [7:0] ss, input logic [15:0] dd);
    @(negedge clk);
    v = 1; t = tt; s = ss; d = dd;
  endtask

  task automatic idle();
    @(negedge clk);
    v = 0;
  endtask

  initial begin
    rst = 1; hlt = 0; v = 0; t = 0; s = 0; d = 0;
    repeat (2) @(negedge clk);
    lit("rst_valid", 32'(a_v), 0);
    lit("rst_data", 32'(a_d), 0);
    rst = 0;
    beat(0, 5, 16'd10); beat(0, 5, 16'hFFFD); beat(0, 5, 16'd7); beat(0, 5, 16'd1);
    idle();
    lit("t1_valid", 32'(a_v), 1);
    lit("t1_data", 32'(a_d), 15);
    lit("t1_seq", 32'(a_s), 5);
    lit("t1_type", 32'(a_t), 0);
    idle();
    lit("t1_valid_drop", 32'(a_v), 0);
    beat(0, 1, 16'd100); beat(0, 1, 16'd100); beat(2, 1, 16'hFFFF);
    beat(0, 1, 16'd100);
    lit("t2_byp_valid", 32'(a_v), 1);
    lit("t2_byp_type", 32'(a_t), 2);
    lit("t2_byp_data", 32'(a_d), 32'h00FFFFFF);
    beat(0, 1, 16'd100);
    idle();
    lit("t2_sum", 32'(a_d), 400);
    lit("t2_seq", 32'(a_s), 1);
    beat(0, 3, 16'd5); beat(0, 3, 16'd5); beat(0, 4, 16'd1); beat(0, 4, 16'd1);
    lit("t3_err", 32'(a_e), 1);
    beat(0, 4, 16'd1);
    lit("t3_err_drop", 32'(a_e), 0);
    beat(0, 4, 16'd1);
    idle();
    lit("t3_valid", 32'(a_v), 1);
    lit("t3_data", 32'(a_d), 4);
    lit("t3_seq", 32'(a_s), 4);
    beat(0, 7, 16'd1); beat(0, 7, 16'd2); beat(0, 7, 16'd3); beat(0, 7, 16'd4);
    @(negedge clk);
    v = 0;
    hlt = 1;
    lit("t4_valid", 32'(a_v), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("t4_hold_valid", 32'(a_v), 1);
      lit("t4_hold_data", 32'(a_d), 10);
    end
    hlt = 0;
    @(negedge clk);
    lit("t4_valid_drop", 32'(a_v), 0);
    beat(0, 8, 16'h7FFF); beat(0, 8, 16'h7FFF); beat(0, 8, 16'h7FFF); beat(0, 8, 16'h7FFF);
    idle();
    lit("t5_data24", 32'(a_d), 32'h0001FFFC);
`ifdef ACC_SAT_EN
    lit("t5_data16", 32'(b_d), 32'h7FFF);
`else
    lit("t5_data16", 32'(b_d), 32'hFFFC);
`endif
    beat(0, 9, 16'd2); beat(0, 9, 16'd2);
    @(negedge clk);
    v = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    beat(0, 9, 16'd2); beat(0, 9, 16'd2); beat(0, 9, 16'd2); beat(0, 9, 16'd2);
    idle();
    lit("t6_valid", 32'(a_v), 1);
    lit("t6_data", 32'(a_d), 8);
    lit("t6_err", 32'(a_e), 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(199) == 0;
      hlt = $urandom_range(9) == 0;
      v = $urandom_range(3) != 0;
      t = $urandom_range(5) == 0 ? 2'($urandom_range(3)) : 2'd0;
      if ($urandom_range(7) == 0) s = 8'($urandom_range(2));
      d = $urandom_range(3) == 0 ? ($urandom_range(1) == 0 ? 16'h7FFF : 16'h8000) : 16'($urandom);
    end
    @(negedge clk);
    v = 0; rst = 0; hlt = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
